time_tx_scheduler: RTL and testbench
====================================

TIME_TX_SCHEDULER -- requirements
Module: time_tx_scheduler

Interface
REQ-001 Parameter: DATA_WIDTH, 8, width of the character output to the UART TX FIFO.
REQ-002 Parameter: FRAME_LEN, 12, characters per time frame; fixed, not to be overridden.
REQ-003 clk  input  1  system clock; single clock domain; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset: rst=0 resets immediately, independent of clk.
REQ-005 req_sw  input  1  stopwatch frame request; one-cycle pulse or level, sampled every cycle.
REQ-006 req_cl  input  1  clock frame request; same semantics as req_sw.
REQ-007 sw_time  input  24  stopwatch BCD digits {hour1,hour0,min1,min0,sec1,sec0}, [23:20]=hour1 ... [3:0]=sec0.
REQ-008 cl_time  input  24  clock BCD digits, same packing as sw_time.
REQ-009 fifo_full  input  1  TX FIFO full; no push is issued while high.
REQ-010 tx_push  output  1  one-cycle write strobe to the TX FIFO.
REQ-011 tx_data  output  DATA_WIDTH  character written when tx_push=1.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle pulse after the last character of a frame is pushed.
REQ-014 grant_src  output  1  source of the current or most recent frame: 0=stopwatch, 1=clock.

Function
REQ-015 The block SHALL have one pending flag per source, set on any clock edge where the matching request is high.
REQ-016 A request while that flag is already set SHALL be absorbed; at most one frame per source is queued.
REQ-017 FSM states: IDLE, SEND, DONE. IDLE goes to SEND when any pending flag is set. SEND goes to DONE on the edge that pushes index FRAME_LEN-1. DONE goes to IDLE unconditionally after 1 cycle.
REQ-018 On the IDLE->SEND edge, the block SHALL grant one source, latch that source's 24-bit time into a snapshot register, clear that source's pending flag, set char index to 0, and update grant_src.
REQ-019 Arbitration SHALL be round-robin. With one flag pending, that source wins. With both pending, the source not granted last wins. Last-grant resets to clock, so the first tie goes to stopwatch.
REQ-020 If a source's request is high on the edge that clears its pending flag, set SHALL win and the flag stays set.
REQ-021 Requests during SEND/DONE SHALL only set pending flags and SHALL NOT disturb the frame in progress.
REQ-022 tx_push SHALL be combinational: (state==SEND) and not fifo_full.
REQ-023 The char index SHALL increment only on edges where tx_push=1. No character is skipped or repeated across fifo_full stalls of any length.
REQ-024 tx_data SHALL be the character at the current index in SEND, else 0x00.
REQ-025 Characters by index:
- 0: 'S'(0x53) for stopwatch, 'C'(0x43) for clock
- 1: 'W'(0x57) for stopwatch, 'L'(0x4C) for clock
- 2: 0x20
- 3: hour1
- 4: hour0
- 5: 0x3A
- 6: min1
- 7: min0
- 8: 0x3A
- 9: sec1
- 10: sec0
- 11: 0x0A
REQ-026 Digit characters SHALL come from the snapshot as 0x30+d for d=0..9 and 0x3F ('?') for d=10..15. Changes on sw_time/cl_time during SEND are ignored.
REQ-027 Minimum latency: request high in cycle k gives pending at edge k+1, SEND at edge k+2, first tx_push in cycle k+2 (fifo_full=0). A 12-char frame with no stalls ends with done in cycle k+14.
REQ-028 The gap between frames SHALL be exactly one DONE cycle plus one IDLE cycle when the other source is pending.

Reset
REQ-029 While rst=0, the block SHALL hold: state=IDLE, pending flags=0, index=0, snapshot=0, last-grant=clock, grant_src=0, tx_push=0, tx_data=0x00, busy=0, done=0.
REQ-030 Reset mid-frame SHALL abort the frame immediately (tx_push drops asynchronously), discard pending requests, and not resume the frame after release.

Verification
REQ-031 Single request: req_sw pulse, sw_time=0x123456, fifo_full=0 -> 12 consecutive pushes "SW 12:34:56\n" (53 57 20 31 32 3A 33 34 3A 35 36 0A), done in cycle k+14.
REQ-032 Simultaneous requests: req_sw=req_cl=1 for one cycle after reset -> stopwatch frame, DONE, IDLE, then clock frame starting "CL "; grant_src 0 then 1.
REQ-033 Backpressure: fifo_full held high 5 cycles after index 3 is pushed -> tx_push=0 and tx_data=hour0 held throughout; the frame completes intact with no duplicates.
REQ-034 Snapshot/absorb: cl_time changes and req_cl pulses 3 times during a clock frame -> the frame carries the old value; exactly one further clock frame follows, with the new value.
REQ-035 Reset mid-frame: rst=0 at index 6 -> tx_push=0 and busy=0 immediately; with no new request after release, no further pushes occur.
REQ-036 Illegal digit: cl_time=0xA00000 -> index 3 char is 0x3F.

Source files
------------

// File: rtl/time_tx_scheduler.sv
// Round-robin scheduler that formats stopwatch/clock BCD snapshots into 12-char text frames for a UART TX FIFO.
// Latency: request to first push is 2 cycles; one push per cycle. Backpressure: fifo_full stalls pushes and holds the index.
module time_tx_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_sw,
    input  logic                  req_cl,
    input  logic [23:0]           sw_time,
    input  logic [23:0]           cl_time,
    input  logic                  fifo_full,
    output logic                  tx_push,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic                  grant_src
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_t;

    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    state_t      state, state_nxt;
    logic        pend_sw, pend_cl;
    logic        last_cl;
    logic [23:0] snap;
    logic [3:0]  idx;
    logic        start;
    logic        pick_cl;
    logic [7:0]  ch;

    function automatic logic [7:0] digit(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pend_sw || pend_cl) state_nxt = ST_SEND;
            ST_SEND: if (tx_push && idx == LAST_IDX) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_push = (state == ST_SEND) && !fifo_full;
        busy    = (state != ST_IDLE);
        done    = (state == ST_DONE);
    end

    // On a tie the source that was not granted last wins.
    assign start   = (state == ST_IDLE) && (pend_sw || pend_cl);
    assign pick_cl = pend_cl && (!pend_sw || !last_cl);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_sw   <= 1'b0;
            pend_cl   <= 1'b0;
            last_cl   <= 1'b1;
            grant_src <= 1'b0;
            snap      <= '0;
            idx       <= '0;
        end else begin
            // A request on the granting edge re-arms the flag it clears.
            pend_sw <= req_sw || (pend_sw && !(start && !pick_cl));
            pend_cl <= req_cl || (pend_cl && !(start && pick_cl));
            if (start) begin
                snap      <= pick_cl ? cl_time : sw_time;
                idx       <= '0;
                grant_src <= pick_cl;
                last_cl   <= pick_cl;
            end else if (tx_push) begin
                idx <= idx + 4'd1;
            end
        end
    end

    always_comb begin
        ch = 8'h00;
        case (idx)
            4'd0:    ch = grant_src ? 8'h43 : 8'h53;
            4'd1:    ch = grant_src ? 8'h4C : 8'h57;
            4'd2:    ch = 8'h20;
            4'd3:    ch = digit(snap[23:20]);
            4'd4:    ch = digit(snap[19:16]);
            4'd5:    ch = 8'h3A;
            4'd6:    ch = digit(snap[15:12]);
            4'd7:    ch = digit(snap[11:8]);
            4'd8:    ch = 8'h3A;
            4'd9:    ch = digit(snap[7:4]);
            4'd10:   ch = digit(snap[3:0]);
            4'd11:   ch = 8'h0A;
            default: ch = 8'h00;
        endcase
    end

    assign tx_data = (state == ST_SEND) ? DATA_WIDTH'(ch) : '0;

endmodule

// File: tb/tb_time_tx_scheduler.sv
// Bench for time_tx_scheduler: directed scenarios plus randomized traffic against a frame-level reference model.
module tb_time_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_sw = 1'b0;
    logic        req_cl = 1'b0;
    logic [23:0] sw_time = '0;
    logic [23:0] cl_time = '0;
    logic        fifo_full = 1'b0;
    logic        tx_push;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;
    logic        grant_src;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] cap[$];
    bit         gs_seen[$];
    int         first_push = -1;
    int         done_cyc = -1;

    // Reference model: mode 0=idle, 1=sending, 2=done
    int         m_mode;
    int         m_idx;
    logic [7:0] m_frame [12];
    bit         m_psw, m_pcl, m_last, m_grant;

    time_tx_scheduler #(.DATA_WIDTH(8), .FRAME_LEN(12)) dut (
        .clk(clk), .rst(rst), .req_sw(req_sw), .req_cl(req_cl),
        .sw_time(sw_time), .cl_time(cl_time), .fifo_full(fifo_full),
        .tx_push(tx_push), .tx_data(tx_data), .busy(busy), .done(done),
        .grant_src(grant_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] dchar(input logic [3:0] d);
        return (d <= 4'd9) ? 8'(8'h30 + d) : 8'h3F;
    endfunction

    function automatic void build(input bit is_cl, input logic [23:0] t);
        m_frame[0]  = is_cl ? "C" : "S";
        m_frame[1]  = is_cl ? "L" : "W";
        m_frame[2]  = " ";
        m_frame[3]  = dchar(t[23:20]);
        m_frame[4]  = dchar(t[19:16]);
        m_frame[5]  = ":";
        m_frame[6]  = dchar(t[15:12]);
        m_frame[7]  = dchar(t[11:8]);
        m_frame[8]  = ":";
        m_frame[9]  = dchar(t[7:4]);
        m_frame[10] = dchar(t[3:0]);
        m_frame[11] = 8'h0A;
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_idx = 0; m_psw = 0; m_pcl = 0; m_last = 1; m_grant = 0;
        for (int i = 0; i < 12; i++) m_frame[i] = 8'h00;
    endfunction

    function automatic void model_update();
        bit push;
        bit g;
        if (!rst) begin
            model_reset();
            return;
        end
        push = (m_mode == 1) && !fifo_full;
        case (m_mode)
            0: if (m_psw || m_pcl) begin
                g = m_pcl && (!m_psw || !m_last);
                build(g, g ? cl_time : sw_time);
                m_idx = 0; m_mode = 1; m_grant = g; m_last = g;
                if (g) m_pcl = 0; else m_psw = 0;
            end
            1: if (push) begin
                m_idx++;
                if (m_idx == 12) m_mode = 2;
            end
            default: m_mode = 0;
        endcase
        if (req_sw) m_psw = 1;
        if (req_cl) m_pcl = 1;
    endfunction

    // Called at a negedge with inputs already driven; ends at the next negedge.
    task automatic step();
        #1;
        chk("tx_push", tx_push, (m_mode == 1) && !fifo_full);
        chk("tx_data", tx_data, (m_mode == 1) ? m_frame[m_idx] : 8'h00);
        chk("busy", busy, m_mode != 0);
        chk("done", done, m_mode == 2);
        chk("grant_src", grant_src, m_grant);
        if (tx_push === 1'b1) begin
            if (cap.size() % 12 == 0) gs_seen.push_back(grant_src);
            cap.push_back(tx_data);
            if (first_push < 0) first_push = cyc;
        end
        if (done === 1'b1) done_cyc = cyc;
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_cap();
        cap.delete();
        gs_seen.delete();
        first_push = -1;
        done_cyc = -1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic run_to_idx(input int n);
        int t = 0;
        while (!(m_mode == 1 && m_idx == n) && t < 50) begin
            step();
            t++;
        end
        chk("reach_idx_timeout", t < 50, 1'b1);
    endtask

    task automatic cmp_frame(input string tag, input int base, input logic [7:0] e [12]);
        for (int i = 0; i < 12; i++)
            chk(tag, (base + i < cap.size()) ? cap[base + i] : 8'hFF, e[i]);
    endtask

    initial begin
        int k;
        logic [7:0] exp_a [12];
        logic [7:0] exp_b [12];

        model_reset();
        @(negedge clk);
        // Reset state held while rst is low
        step();
        step();
        rst = 1'b1;

        // Single stopwatch request with latency measurement
        clear_cap();
        exp_a = '{8'h53, 8'h57, 8'h20, 8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0A};
        sw_time = 24'h123456;
        req_sw = 1'b1;
        k = cyc;
        step();
        req_sw = 1'b0;
        repeat (20) step();
        chk("single_count", cap.size(), 12);
        cmp_frame("single_char", 0, exp_a);
        chk("first_push_cycle", first_push, k + 2);
        chk("done_cycle", done_cyc, k + 14);

        // Simultaneous requests right after reset: stopwatch first, then clock
        do_reset();
        clear_cap();
        cl_time = 24'h010203;
        req_sw = 1'b1;
        req_cl = 1'b1;
        step();
        req_sw = 1'b0;
        req_cl = 1'b0;
        repeat (35) step();
        chk("tie_count", cap.size(), 24);
        chk("tie_first_c0", cap.size() > 0 ? cap[0] : 8'hFF, 8'h53);
        chk("tie_second_c0", cap.size() > 12 ? cap[12] : 8'hFF, 8'h43);
        chk("tie_second_c1", cap.size() > 13 ? cap[13] : 8'hFF, 8'h4C);
        chk("tie_second_c2", cap.size() > 14 ? cap[14] : 8'hFF, 8'h20);
        chk("tie_grant0", gs_seen.size() > 0 ? gs_seen[0] : 1'bx, 1'b0);
        chk("tie_grant1", gs_seen.size() > 1 ? gs_seen[1] : 1'bx, 1'b1);

        // Backpressure after index 3 is pushed
        clear_cap();
        exp_b = '{8'h53, 8'h57, 8'h20, 8'h30, 8'h39, 8'h3A, 8'h30, 8'h38, 8'h3A, 8'h30, 8'h37, 8'h0A};
        sw_time = 24'h090807;
        req_sw = 1'b1;
        step();
        req_sw = 1'b0;
        run_to_idx(4);
        fifo_full = 1'b1;
        repeat (5) begin
            #1;
            chk("bp_push_low", tx_push, 1'b0);
            chk("bp_hold_hour0", tx_data, 8'h39);
            step();
        end
        fifo_full = 1'b0;
        repeat (20) step();
        chk("bp_count", cap.size(), 12);
        cmp_frame("bp_char", 0, exp_b);

        // Snapshot and absorb: one old-value frame, then exactly one new-value frame
        clear_cap();
        cl_time = 24'h111111;
        req_cl = 1'b1;
        step();
        req_cl = 1'b0;
        step();
        cl_time = 24'h222222;
        repeat (3) begin
            req_cl = 1'b1;
            step();
            req_cl = 1'b0;
            step();
        end
        repeat (40) step();
        chk("absorb_count", cap.size(), 24);
        chk("absorb_old_h1", cap.size() > 3 ? cap[3] : 8'hFF, 8'h31);
        chk("absorb_old_s0", cap.size() > 10 ? cap[10] : 8'hFF, 8'h31);
        chk("absorb_new_h1", cap.size() > 15 ? cap[15] : 8'hFF, 8'h32);
        chk("absorb_new_s0", cap.size() > 22 ? cap[22] : 8'hFF, 8'h32);

        // Asynchronous reset mid-frame at index 6
        clear_cap();
        sw_time = 24'h235959;
        req_sw = 1'b1;
        step();
        req_sw = 1'b0;
        run_to_idx(6);
        #2 rst = 1'b0;
        #1;
        chk("arst_push", tx_push, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_data", tx_data, 8'h00);
        model_reset();
        step();
        step();
        rst = 1'b1;
        clear_cap();
        repeat (20) step();
        chk("arst_no_resume", cap.size(), 0);

        // Illegal BCD digit
        clear_cap();
        cl_time = 24'hA00000;
        req_cl = 1'b1;
        step();
        req_cl = 1'b0;
        repeat (20) step();
        chk("illegal_h1", cap.size() > 3 ? cap[3] : 8'hFF, 8'h3F);
        chk("illegal_h0", cap.size() > 4 ? cap[4] : 8'hFF, 8'h30);

        // Randomized traffic with stalls and occasional resets
        for (int i = 0; i < 3000; i++) begin
            req_sw = ($urandom_range(0, 7) == 0);
            req_cl = ($urandom_range(0, 7) == 0);
            fifo_full = ($urandom_range(0, 3) == 0);
            if (i % 16 == 0) begin
                sw_time = 24'($urandom);
                cl_time = 24'($urandom);
            end
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b0;
                model_reset();
            end else begin
                rst = 1'b1;
            end
            step();
        end
        req_sw = 1'b0;
        req_cl = 1'b0;
        fifo_full = 1'b0;
        rst = 1'b1;
        repeat (40) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
